rom_stream_reader: RTL
======================

# rom_stream_reader

Sequencer that sits directly upstream of the combinational `rom64x16` ROM: drives its `addr`, samples its `rdata`, and streams a contiguous run of ROM words out over a valid/ready handshake. A single `start` pulse launches a burst of `length` words beginning at `base_addr`. Addresses wrap at the end of the ROM. Downstream back-pressure is honoured without losing or duplicating words.

## Interface
- `ADDR_WIDTH`, 6, ROM address width.
- `DATA_WIDTH`, 16, ROM word width.
- `MEM_CAPACITY`, 64, number of ROM words; `MEM_CAPACITY` ≤ 2^`ADDR_WIDTH`.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch burst; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first word address; sampled with `start`.
- `length`  in  ADDR_WIDTH+1  word count; sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the burst is complete.
- `rom_addr`  out  ADDR_WIDTH  registered address to the ROM `addr` port.
- `rom_rdata`  in  DATA_WIDTH  ROM `rdata`, combinational from `rom_addr`.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_last`  out  1  marks the final word of the burst; qualified by `m_valid`.
- `m_ready`  in  1  downstream accepts when `m_valid & m_ready`.
- `checksum`  out  DATA_WIDTH  burst XOR checksum (see Configuration).

## Operation
- The clock and reset are as stated under Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: `busy`=0, `done`=0, `rom_addr`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `checksum`=0. The FSM resets to IDLE. Reset mid-burst discards all in-flight words; no `done` pulse follows.
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE:**
  - On `start` with `length`≥1, latch `rom_addr`←`base_addr`, then go to FETCH.
  - If `base_addr` ≥ `MEM_CAPACITY`, `rom_addr`←0.
  - `remaining`←min(`length`, `MEM_CAPACITY`).
  - On `start` with `length`=0, pulse `done` next cycle, stay in IDLE, and emit no words.
- **FETCH:**
  - Capture condition: `!m_valid | m_ready`.
  - On capture:
    - `m_data`←`rom_rdata`.
    - `m_valid`←1.
    - `m_last`←(`remaining`==1).
    - `remaining` decrements.
    - `rom_addr` increments, wrapping `MEM_CAPACITY-1`→0.
  - After capturing the last word, go to DRAIN.
- **DRAIN:** on `m_valid & m_ready`, clear `m_valid`/`m_last`, pulse `done`, go to IDLE.
- In FETCH, when `m_valid & m_ready` occurs without a new capture, `m_valid` clears.
- Once `m_valid` is high, `m_data`, `m_last` and `m_valid` stay stable until accepted.
- `start` while `busy` is ignored.

## Timing
- `start` is sampled on edge T0.
- `busy`=1 and `rom_addr`=`base_addr` after T0.
- First word is captured at T1; `m_valid`=1 after T1. Start-to-first-valid latency is 2 edges.
- With `m_ready` held high, throughput is 1 word/cycle. An N-word burst shows `m_valid` on cycles T1..T(N), with `m_last` on the Nth.
- `done` is asserted for the cycle after the last handshake; `busy` drops together with `done`.
- `m_ready` low stalls `rom_addr` and `remaining`. There is no combinational path from `m_ready` to `m_valid`.

## Configuration
- `ROM_STREAM_CHECKSUM_EN`:
  - **Defined:**
    - `checksum` clears on an accepted `start`.
    - It XOR-accumulates every accepted `m_data` word.
    - Final value is stable from the `done` cycle until the next `start`.
  - **Undefined:** `checksum` is tied to 0 and no accumulator is synthesised.

## Test plan
- ROM with `data[i]`=i×3, `base_addr`=5, `length`=4, `m_ready`=1 -> `m_data` 15,18,21,24 on consecutive cycles; `m_last` on 24; `done` one cycle later.
- `base_addr`=62, `length`=4 -> addresses 62,63,0,1 in order; 4 words; `m_last` on the word read from address 1.
- `m_ready` toggling 1,0,0,1,... during a 6-word burst -> every word appears exactly once, in order; `m_data` is stable while stalled.
- `length`=0 -> `done` pulse next cycle; `m_valid` never high. `length`=100 -> exactly 64 words emitted.
- Reset asserted mid-burst (after 2 of 8 words) -> all outputs at reset values immediately; no `done`; the next `start` runs a full burst.
- With `ROM_STREAM_CHECKSUM_EN`: `base_addr`=0, `length`=4 on `data[i]`=i×3 -> `checksum`=0^3^6^9=0x000C at `done`. Without the macro, `checksum`=0 throughout.

Source files
------------

// File: rtl/rom_stream_reader_if.sv
// Output stream bundle for rom_stream_reader.
// Handshake: the master raises m_valid with m_data/m_last. Once m_valid is
// high, m_valid, m_data and m_last hold steady until the slave accepts.
// A word transfers on any rising edge where m_valid & m_ready are both high.
// m_last is meaningful only while m_valid is high.
interface rom_stream_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: drives the address of a combinational ROM and streams a
// contiguous, wrapping run of words out over a valid/ready interface.
// Optional feature macro: ROM_STREAM_CHECKSUM_EN enables the burst XOR
// checksum; when undefined, checksum is tied to zero.
// dbg_state exposes the FSM state (0=IDLE, 1=FETCH, 2=DRAIN).
module rom_stream_reader #(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 16,
    parameter int MEM_CAPACITY = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [1:0]            dbg_state,
    rom_stream_reader_if.master   m
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CAP     = (ADDR_WIDTH+1)'(MEM_CAPACITY);
    localparam logic [ADDR_WIDTH-1:0] LAST_AD = ADDR_WIDTH'(MEM_CAPACITY - 1);
    localparam logic [ADDR_WIDTH:0]   ONE     = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH:0]   rem_q, rem_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  last_q, last_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic                  capture;

    // The output register is free when empty or being drained this cycle.
    assign accept  = valid_q & m.m_ready;
    assign capture = (state_q == FETCH) & (~valid_q | m.m_ready);

    // Next-state and datapath decode; everything holds unless a case moves it.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        // Out-of-range base restarts at word 0; over-long bursts clamp to one ROM pass.
                        addr_d  = ({1'b0, base_addr} >= CAP) ? '0 : base_addr;
                        rem_d   = (length > CAP) ? CAP : length;
                        busy_d  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (capture) begin
                    data_d  = rom_rdata;
                    valid_d = 1'b1;
                    last_d  = (rem_q == ONE);
                    rem_d   = rem_q - ONE;
                    addr_d  = (addr_q == LAST_AD) ? '0 : addr_q + 1'b1;
                    if (rem_q == ONE) begin
                        state_d = DRAIN;
                    end
                end else if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef ROM_STREAM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] cs_q;

    // Clear on a start taken in IDLE, then fold in every accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            cs_q <= '0;
        end else if (accept) begin
            cs_q <= cs_q ^ data_q;
        end
    end

    assign checksum = cs_q;
`else
    assign checksum = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign rom_addr  = addr_q;
    assign dbg_state = state_q;
    assign m.m_valid = valid_q;
    assign m.m_data  = data_q;
    assign m.m_last  = last_q;

endmodule
